cam_pattern_tx: RTL and testbench

CAM_PATTERN_TX -- requirements
Module: cam_pattern_tx

---
 rtl/cam_tx_pkg.sv | 39 +++
 rtl/cam_tx_pattern_gen.sv | 31 +++
 rtl/cam_pattern_tx.sv | 134 +++++++++++++
 tb/tb_cam_pattern_tx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cam_tx_pkg.sv
// rtl/cam_tx_pkg.sv - shared states, pattern codes and bar colours for cam_pattern_tx
package cam_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VSYNC,
      ST_VBP,
      ST_ACTIVE,
      ST_VFP
   } tx_state_t;

   localparam logic [1:0] PAT_BARS    = 2'd0;
   localparam logic [1:0] PAT_RAMP    = 2'd1;
   localparam logic [1:0] PAT_COUNT   = 2'd2;
   localparam logic [1:0] PAT_CHECKER = 2'd3;

   localparam logic [11:0] BAR_0 = 12'hFFF;
   localparam logic [11:0] BAR_1 = 12'hFF0;
   localparam logic [11:0] BAR_2 = 12'h0FF;
   localparam logic [11:0] BAR_3 = 12'h0F0;
   localparam logic [11:0] BAR_4 = 12'hF0F;
   localparam logic [11:0] BAR_5 = 12'hF00;
   localparam logic [11:0] BAR_6 = 12'h00F;
   localparam logic [11:0] BAR_7 = 12'h000;

   function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_0;
         3'd1:    return BAR_1;
         3'd2:    return BAR_2;
         3'd3:    return BAR_3;
         3'd4:    return BAR_4;
         3'd5:    return BAR_5;
         3'd6:    return BAR_6;
         default: return BAR_7;
      endcase
   endfunction

endpackage

// File: rtl/cam_tx_pattern_gen.sv
// rtl/cam_tx_pattern_gen.sv - combinational RGB444 colour for one pixel position
module cam_tx_pattern_gen
   import cam_tx_pkg::*;
#(
   parameter int ACT_W     = 640,
   parameter int CHK_SHIFT = 5
)
(
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [3:0]  frame_cnt,
   input  logic [1:0]  pattern,
   output logic [11:0] rgb
);

   logic [2:0] bar;
   logic       chk_on;

   always_comb begin
      bar    = 3'(x / 16'(ACT_W / 8));
      chk_on = |(((x >> CHK_SHIFT) ^ (y >> CHK_SHIFT)) & 16'h0001);
      rgb    = 12'h000;
      case (pattern)
         PAT_BARS:  rgb = bar_rgb(bar);
         PAT_RAMP:  rgb = {3{x[3:0]}};
         PAT_COUNT: rgb = {3{frame_cnt}};
         default:   rgb = chk_on ? 12'hFFF : 12'h000;
      endcase
   end

endmodule

// File: rtl/cam_pattern_tx.sv
// rtl/cam_pattern_tx.sv - OV7670-style RGB444 test pattern byte stream with href/vsync framing
module cam_pattern_tx
   import cam_tx_pkg::*;
#(
   parameter int ACT_W       = 640,
   parameter int ACT_H       = 480,
   parameter int HBLANK      = 144,
   parameter int VSYNC_LINES = 3,
   parameter int VBP_LINES   = 17,
   parameter int VFP_LINES   = 10,
   parameter int CHK_SHIFT   = 5
)
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_pclk_en,
   input  logic       i_run,
   input  logic [1:0] i_pattern,
   output logic [7:0] o_pix_byte,
   output logic       o_href,
   output logic       o_vsync,
   output logic       o_frame_done,
   output logic       o_busy
);

   localparam int L   = 2 * ACT_W + HBLANK;
   localparam int H_W = $clog2(L);
   localparam int V_W = $clog2(VSYNC_LINES + VBP_LINES + ACT_H + VFP_LINES + 1);

   tx_state_t        state, state_nxt;
   logic [H_W-1:0]   h_cnt, h_nxt;
   logic [V_W-1:0]   v_cnt, v_nxt;
   logic [7:0]       frame_cnt;
   logic [1:0]       pat_lat;
   logic             slot_last, line_last, frame_end;
   logic             href_nxt, pat_load;
   logic [7:0]       byte_nxt;
   logic [11:0]      rgb;

   always_comb begin
      slot_last = (h_cnt == H_W'(L - 1));
      line_last = 1'b0;
      case (state)
         ST_VSYNC:  line_last = (v_cnt == V_W'(VSYNC_LINES - 1));
         ST_VBP:    line_last = (v_cnt == V_W'(VBP_LINES - 1));
         ST_ACTIVE: line_last = (v_cnt == V_W'(ACT_H - 1));
         ST_VFP:    line_last = (v_cnt == V_W'(VFP_LINES - 1));
         default:   line_last = 1'b0;
      endcase
   end

   // Pure next-slot logic; the pixel enable gates the commit in the register process.
   always_comb begin
      state_nxt = state;
      h_nxt     = h_cnt;
      v_nxt     = v_cnt;
      frame_end = 1'b0;
      if (state == ST_IDLE) begin
         if (i_run) begin
            state_nxt = ST_VSYNC;
            h_nxt     = '0;
            v_nxt     = '0;
         end
      end else if (slot_last) begin
         h_nxt = '0;
         v_nxt = line_last ? '0 : v_cnt + 1'b1;
         if (line_last) begin
            case (state)
               ST_VSYNC:  state_nxt = ST_VBP;
               ST_VBP:    state_nxt = ST_ACTIVE;
               ST_ACTIVE: state_nxt = ST_VFP;
               default: begin
                  frame_end = 1'b1;
                  state_nxt = i_run ? ST_VSYNC : ST_IDLE;
               end
            endcase
         end
      end else begin
         h_nxt = h_cnt + 1'b1;
      end
   end

   cam_tx_pattern_gen #(
      .ACT_W     (ACT_W),
      .CHK_SHIFT (CHK_SHIFT)
   ) u_pattern_gen (
      .x         (16'(h_nxt >> 1)),
      .y         (16'(v_nxt)),
      .frame_cnt (frame_cnt[3:0]),
      .pattern   (pat_lat),
      .rgb       (rgb)
   );

   // Outputs are computed for the slot being entered so they appear on the same edge as the state.
   always_comb begin
      href_nxt = (state_nxt == ST_ACTIVE) && (h_nxt < H_W'(2 * ACT_W));
      byte_nxt = 8'h00;
      if (href_nxt)
         byte_nxt = h_nxt[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
      pat_load = (state_nxt == ST_VSYNC) && (state != ST_VSYNC);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= ST_IDLE;
         h_cnt        <= '0;
         v_cnt        <= '0;
         frame_cnt    <= 8'd0;
         pat_lat      <= 2'd0;
         o_pix_byte   <= 8'h00;
         o_href       <= 1'b0;
         o_vsync      <= 1'b0;
         o_frame_done <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;
         if (i_pclk_en) begin
            state        <= state_nxt;
            h_cnt        <= h_nxt;
            v_cnt        <= v_nxt;
            o_pix_byte   <= byte_nxt;
            o_href       <= href_nxt;
            o_vsync      <= (state_nxt == ST_VSYNC);
            o_busy       <= (state_nxt != ST_IDLE);
            o_frame_done <= frame_end;
            if (frame_end)
               frame_cnt <= frame_cnt + 1'b1;
            if (pat_load)
               pat_lat <= i_pattern;
         end
      end
   end

endmodule

// File: tb/tb_cam_pattern_tx.sv
// tb/tb_cam_pattern_tx.sv - directed self-checking bench for cam_pattern_tx on a small 8x2 frame
module tb_cam_pattern_tx;

   localparam int L = 18;
   localparam int FRAME_SLOTS = 5 * L;

   // Line 0 bytes for the colour bars, one bar per pixel at ACT_W=8.
   localparam logic [7:0] BAR_BYTES [16] = '{
      8'h0F, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hF0,
      8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00
   };

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_pclk_en = 1'b0;
   logic       i_run = 1'b0;
   logic [1:0] i_pattern = 2'd0;
   logic [7:0] o_pix_byte;
   logic       o_href, o_vsync, o_frame_done, o_busy;
   logic [11:0] obs;

   int n_total = 0;
   int n_bad   = 0;

   cam_pattern_tx #(
      .ACT_W       (8),
      .ACT_H       (2),
      .HBLANK      (2),
      .VSYNC_LINES (1),
      .VBP_LINES   (1),
      .VFP_LINES   (1),
      .CHK_SHIFT   (1)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_pclk_en    (i_pclk_en),
      .i_run        (i_run),
      .i_pattern    (i_pattern),
      .o_pix_byte   (o_pix_byte),
      .o_href       (o_href),
      .o_vsync      (o_vsync),
      .o_frame_done (o_frame_done),
      .o_busy       (o_busy)
   );

   always #5 i_clk = ~i_clk;

   assign obs = {o_busy, o_vsync, o_href, o_frame_done, o_pix_byte};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // {busy, vsync, href, frame_done, byte} for slot k of a frame.
   function automatic logic [11:0] exp_slot(input int k, input int pat, input int fc, input bit fd);
      int line, h, x;
      logic href;
      logic [11:0] rgb;
      logic [7:0] pb;
      logic [7:0] chk_on;
      chk_on = 8'hCC;
      line = k / L;
      h    = k % L;
      x    = h / 2;
      href = (line == 2 || line == 3) && (h < 16);
      rgb  = 12'h000;
      case (pat)
         1: rgb = {3{4'(x)}};
         2: rgb = {3{4'(fc)}};
         3: if (x < 8) rgb = chk_on[x] ? 12'hFFF : 12'h000;
         default: rgb = 12'h000;
      endcase
      pb = (h % 2 == 0) ? {4'h0, rgb[11:8]} : rgb[7:0];
      if (pat == 0 && href) pb = BAR_BYTES[h];
      if (!href) pb = 8'h00;
      return {1'b1, (line == 0), href, fd, pb};
   endfunction

   task automatic play_frame(input int pat, input int fc, input bit tog, input bit fd0,
                             input int drop_at, input int chg_at, input logic [1:0] chg_pat);
      for (int k = 0; k < FRAME_SLOTS; k++) begin
         i_pclk_en = 1'b1;
         step();
         check_eq($sformatf("p%0d_f%0d_slot%0d", pat, fc, k), 32'(obs),
                  32'(exp_slot(k, pat, fc, (k == 0) && fd0)));
         if (k == drop_at) i_run = 1'b0;
         if (k == chg_at) i_pattern = chg_pat;
         if (tog) begin
            i_pclk_en = 1'b0;
            step();
            check_eq($sformatf("p%0d_f%0d_hold%0d", pat, fc, k), 32'(obs),
                     32'(exp_slot(k, pat, fc, 1'b0)));
         end
      end
   endtask

   task automatic finish_frame(input bit tog);
      i_pclk_en = 1'b1;
      step();
      check_eq("frame_done", 32'(obs), 32'h100);
      i_pclk_en = !tog;
      step();
      check_eq("idle_after", 32'(obs), 32'h000);
   endtask

   initial begin
      step();
      step();
      check_eq("reset_outputs", 32'(obs), 32'h000);
      i_rst = 1'b0;

      // single frame of colour bars from a one-cycle run pulse
      i_pattern = 2'd0;
      i_run     = 1'b1;
      play_frame(0, 0, 1'b0, 1'b0, 0, -1, 2'd0);
      finish_frame(1'b0);

      // ramp with the slot enable toggling every cycle
      i_pattern = 2'd1;
      i_run     = 1'b1;
      play_frame(1, 1, 1'b1, 1'b0, 0, -1, 2'd0);
      finish_frame(1'b1);

      // frame counter back-to-back after a reset clears it
      i_rst = 1'b1;
      step();
      check_eq("reset_again", 32'(obs), 32'h000);
      i_rst     = 1'b0;
      i_pattern = 2'd2;
      i_run     = 1'b1;
      play_frame(2, 0, 1'b0, 1'b0, -1, -1, 2'd0);
      play_frame(2, 1, 1'b0, 1'b1, -1, -1, 2'd0);
      play_frame(2, 2, 1'b0, 1'b1, 30, -1, 2'd0);
      finish_frame(1'b0);

      // pattern change mid-active applies only to the next frame
      i_pattern = 2'd3;
      i_run     = 1'b1;
      play_frame(3, 3, 1'b0, 1'b0, -1, 50, 2'd1);
      play_frame(1, 4, 1'b0, 1'b1, 5, -1, 2'd0);
      finish_frame(1'b0);

      // reset mid-active aborts, then restarts with run held
      i_pattern = 2'd0;
      i_run     = 1'b1;
      i_pclk_en = 1'b1;
      for (int k = 0; k < 45; k++) begin
         step();
         check_eq($sformatf("abort_slot%0d", k), 32'(obs), 32'(exp_slot(k, 0, 0, 1'b0)));
      end
      i_rst = 1'b1;
      step();
      check_eq("abort_reset", 32'(obs), 32'h000);
      i_rst = 1'b0;
      step();
      check_eq("restart_vsync", 32'(obs), 32'(exp_slot(0, 0, 0, 1'b0)));
      i_run = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
